// File: rtl/uart_loader_pkg.sv
// Shared constants and state types for the UART memory loader.
package uart_loader_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam logic [7:0] CMD_WRITE   = 8'h01;
    localparam logic [7:0] CMD_READ    = 8'h02;
    localparam logic [7:0] CMD_RST_SET = 8'h03;
    localparam logic [7:0] CMD_RST_CLR = 8'h04;
    localparam logic [7:0] ACK_BYTE    = 8'h5A;
    localparam logic [7:0] NAK_BYTE    = 8'hEE;

    typedef enum logic [3:0] {
        ST_IDLE, ST_CMD, ST_ADDR_HI, ST_ADDR_LO,
        ST_D0, ST_D1, ST_D2, ST_D3,
        ST_EXEC, ST_RD_WAIT, ST_RESP
    } parser_state_t;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_mem_loader_if.sv
// Single-word memory access port (DMA side of the L1 RAMs).
interface uart_mem_loader_if #(
    parameter int unsigned ADDR_WIDTH = 13
);
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport master (output mem_en, mem_we, mem_addr, mem_wdata, input mem_rdata);
    modport slave  (input mem_en, mem_we, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/uart_mem_loader_phy.sv
// UART byte PHY: rxd synchronizer, mid-bit RX sampler, 8N1 TX shifter.
module uart_phy
    import uart_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 964
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       rxd,
    output logic       txd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    rx_sync;
    logic          rx_prev;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_valid_d, rx_ferr_d;
    logic          rx_s;

    logic          tx_active;
    logic [9:0]    tx_shift;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic          tx_last;

    assign rx_s    = rx_sync[1];
    assign rx_data = rx_shift_q;

    // Two-stage synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rx_sync <= '1;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rxd};
            rx_prev <= rx_sync[1];
        end
    end

    // RX sampler state and datapath registers.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid   <= 1'b0;
            rx_ferr    <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid   <= rx_valid_d;
            rx_ferr    <= rx_ferr_d;
        end
    end

    // RX next state: start re-check at half bit, data and stop at bit centres.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (rx_prev && !rx_s) begin
                rx_state_d = RX_START;
                rx_cnt_d   = '0;
            end
            RX_START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            end else rx_cnt_d = rx_cnt_q + 1'b1;
            RX_DATA: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_s, rx_shift_q[7:1]};
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                else                  rx_bit_d   = rx_bit_q + 1'b1;
            end else rx_cnt_d = rx_cnt_q + 1'b1;
            RX_STOP: if (rx_cnt_q == BIT_LAST) begin
                rx_state_d = RX_IDLE;
                rx_valid_d = rx_s;
                rx_ferr_d  = !rx_s;
            end else rx_cnt_d = rx_cnt_q + 1'b1;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Busy drops in the final stop-bit cycle so the next byte can follow with no gap.
    assign tx_last = tx_active && (tx_bit == 4'd9) && (tx_cnt == BIT_LAST);
    assign tx_busy = tx_active && !tx_last;
    assign txd     = tx_active ? tx_shift[0] : 1'b1;

    // TX shifter: start bit, 8 data bits LSB first, stop bit.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            tx_active <= 1'b0;
            tx_shift  <= '1;
            tx_cnt    <= '0;
            tx_bit    <= '0;
        end else if (tx_start && !tx_busy) begin
            tx_active <= 1'b1;
            tx_shift  <= {1'b1, tx_data, 1'b0};
            tx_cnt    <= '0;
            tx_bit    <= '0;
        end else if (tx_active) begin
            if (tx_cnt == BIT_LAST) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    tx_active <= 1'b0;
                end else begin
                    tx_bit   <= tx_bit + 1'b1;
                    tx_shift <= {1'b1, tx_shift[9:1]};
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_mem_loader.sv
// Serial host bridge: decodes A5-framed commands into single-word memory
// accesses and core-reset control, and returns ACK/NAK/read data over UART.
module uart_mem_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = 964,
    parameter int unsigned ADDR_WIDTH     = 13,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      resetb,
    input  logic                      rxd,
    output logic                      txd,
    uart_mem_loader_if.master         mem,
    output logic                      core_reset,
    output logic                      busy,
    output logic                      err
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [7:0]    rx_data, tx_data;
    logic          rx_valid, rx_ferr, tx_start, tx_busy;

    parser_state_t state_q, state_d;
    logic [7:0]    cmd_q, cmd_d, resp_code_q, resp_code_d;
    logic [15:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [2:0]    resp_len_q, resp_len_d, resp_idx_q, resp_idx_d;
    logic          core_reset_q, core_reset_d, err_q, err_d;
    logic [TW-1:0] to_cnt;
    logic          in_frame, to_expired, addr_bad, mem_cmd, exec_access;

    uart_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
        .clk(clk), .resetb(resetb), .rxd(rxd), .txd(txd),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
    );

    assign in_frame    = state_q inside {ST_CMD, ST_ADDR_HI, ST_ADDR_LO, ST_D0, ST_D1, ST_D2, ST_D3};
    assign to_expired  = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign addr_bad    = (({16'h0, addr_q} >> ADDR_WIDTH) != 32'h0);
    assign mem_cmd     = (cmd_q == CMD_WRITE) || (cmd_q == CMD_READ);
    assign exec_access = (state_q == ST_EXEC) && mem_cmd && !addr_bad;

    assign mem.mem_en    = exec_access;
    assign mem.mem_we    = exec_access && (cmd_q == CMD_WRITE);
    assign mem.mem_addr  = addr_q[ADDR_WIDTH-1:0];
    assign mem.mem_wdata = wdata_q;
    assign core_reset    = core_reset_q;
    assign busy          = (state_q != ST_IDLE);
    assign err           = err_q;

    // Response byte select: status byte first, then read data MSB first.
    always_comb begin
        case (resp_idx_q)
            3'd1:    tx_data = rdata_q[31:24];
            3'd2:    tx_data = rdata_q[23:16];
            3'd3:    tx_data = rdata_q[15:8];
            3'd4:    tx_data = rdata_q[7:0];
            default: tx_data = resp_code_q;
        endcase
    end

    // Inter-byte timeout: counts idle cycles while a frame is partially received.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)                   to_cnt <= '0;
        else if (!in_frame || rx_valid) to_cnt <= '0;
        else                           to_cnt <= to_cnt + 1'b1;
    end

    // Parser state and frame registers.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            resp_code_q  <= '0;
            resp_len_q   <= '0;
            resp_idx_q   <= '0;
            core_reset_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            resp_code_q  <= resp_code_d;
            resp_len_q   <= resp_len_d;
            resp_idx_q   <= resp_idx_d;
            core_reset_q <= core_reset_d;
            err_q        <= err_d;
        end
    end

    // Parser next state, command execution and response sequencing.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        resp_code_d  = resp_code_q;
        resp_len_d   = resp_len_q;
        resp_idx_d   = resp_idx_q;
        core_reset_d = core_reset_q;
        err_d        = rx_ferr;
        tx_start     = 1'b0;
        case (state_q)
            ST_IDLE: if (rx_valid && rx_data == SYNC_BYTE) state_d = ST_CMD;
            ST_CMD: if (rx_valid) begin
                cmd_d = rx_data;
                if (rx_data inside {CMD_WRITE, CMD_READ, CMD_RST_SET, CMD_RST_CLR}) begin
                    state_d = ST_ADDR_HI;
                end else begin
                    err_d       = 1'b1;
                    resp_code_d = NAK_BYTE;
                    resp_len_d  = 3'd1;
                    resp_idx_d  = '0;
                    state_d     = ST_RESP;
                end
            end
            ST_ADDR_HI: if (rx_valid) begin
                addr_d[15:8] = rx_data;
                state_d      = ST_ADDR_LO;
            end
            // core_reset is loaded here so the register output changes during EXEC.
            ST_ADDR_LO: if (rx_valid) begin
                addr_d[7:0] = rx_data;
                if (cmd_q == CMD_RST_SET) core_reset_d = 1'b1;
                if (cmd_q == CMD_RST_CLR) core_reset_d = 1'b0;
                state_d = (cmd_q == CMD_WRITE) ? ST_D0 : ST_EXEC;
            end
            ST_D0: if (rx_valid) begin wdata_d = {wdata_q[23:0], rx_data}; state_d = ST_D1; end
            ST_D1: if (rx_valid) begin wdata_d = {wdata_q[23:0], rx_data}; state_d = ST_D2; end
            ST_D2: if (rx_valid) begin wdata_d = {wdata_q[23:0], rx_data}; state_d = ST_D3; end
            ST_D3: if (rx_valid) begin wdata_d = {wdata_q[23:0], rx_data}; state_d = ST_EXEC; end
            ST_EXEC: begin
                resp_code_d = ACK_BYTE;
                resp_len_d  = 3'd1;
                resp_idx_d  = '0;
                state_d     = ST_RESP;
                if (mem_cmd && addr_bad) begin
                    err_d       = 1'b1;
                    resp_code_d = NAK_BYTE;
                end else if (cmd_q == CMD_READ) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                rdata_d    = mem.mem_rdata;
                resp_len_d = 3'd5;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rx_valid) err_d = 1'b1;
                if (!tx_busy) begin
                    if (resp_idx_q == resp_len_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        tx_start   = 1'b1;
                        resp_idx_d = resp_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (in_frame && !rx_valid && to_expired) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader: UART frames in, memory accesses and TX bytes out.
module tb_uart_mem_loader;
    import uart_loader_pkg::*;

    localparam int unsigned CPB   = 8;
    localparam int unsigned AW    = 13;
    localparam int unsigned TMO   = 400;
    localparam int unsigned LIMIT = 2000;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    logic rxd = 1'b1;
    logic txd, core_reset, busy, err;

    uart_mem_loader_if #(.ADDR_WIDTH(AW)) mem_bus();

    uart_mem_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .resetb(resetb), .rxd(rxd), .txd(txd), .mem(mem_bus),
        .core_reset(core_reset), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int err_cnt  = 0;

    typedef struct { logic we; logic [AW-1:0] addr; logic [31:0] wdata; } acc_t;
    typedef struct { logic [7:0] data; logic stop; int cyc; } txb_t;
    acc_t       acc_q[$];
    txb_t       tx_q[$];
    logic [7:0] exp_q[$];

    logic [31:0]   mem_model [0:(1<<AW)-1];
    logic          rd_pend = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (err === 1'b1) err_cnt++;

    // Memory model: read data appears one cycle after the read strobe.
    always @(negedge clk) begin
        mem_bus.mem_rdata = rd_pend ? mem_model[rd_addr] : 32'hBAD0_BAD0;
        rd_pend = (mem_bus.mem_en === 1'b1) && (mem_bus.mem_we === 1'b0);
        rd_addr = mem_bus.mem_addr;
        if (mem_bus.mem_en === 1'b1) begin
            acc_q.push_back('{mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata});
            if (mem_bus.mem_we === 1'b1) mem_model[mem_bus.mem_addr] = mem_bus.mem_wdata;
        end
    end

    // TX line decoder: samples each bit at its centre.
    initial begin
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                automatic txb_t b;
                b.cyc = cyc;
                repeat (CPB/2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b.data[i] = txd;
                end
                repeat (CPB) @(negedge clk);
                b.stop = txd;
                tx_q.push_back(b);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0; repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin rxd = b[i]; repeat (CPB) @(negedge clk); end
        rxd = stop; repeat (CPB) @(negedge clk);
        rxd = 1'b1; repeat (2*CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] fr[$]);
        foreach (fr[i]) send_byte(fr[i], 1'b1);
    endtask

    // Waits for n TX bytes and the parser returning idle; reports timeout and end cycle.
    task automatic wait_resp(input int n, output bit timed_out, output int end_cyc);
        int k = 0;
        while (tx_q.size() < n && k < LIMIT) begin @(negedge clk); k++; end
        while (busy === 1'b1 && k < LIMIT) begin @(negedge clk); k++; end
        timed_out = (k >= LIMIT);
        end_cyc   = cyc;
    endtask

    task automatic check_reset_values(input string tag);
        logic [31:0] obs[8];
        logic [31:0] expv[8];
        string       nm[8];
        obs = '{32'(txd), 32'(mem_bus.mem_en), 32'(mem_bus.mem_we), 32'(mem_bus.mem_addr),
                mem_bus.mem_wdata, 32'(core_reset), 32'(busy), 32'(err)};
        expv = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        nm   = '{"txd", "mem_en", "mem_we", "mem_addr", "mem_wdata", "core_reset", "busy", "err"};
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (obs[i] !== expv[i]) begin
                n_fail++;
                $display("FAIL %s_%s: got %h required %h", tag, nm[i], obs[i], expv[i]);
            end
        end
    endtask

    task automatic test_reset;
        resetb = 1'b0; rxd = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        resetb = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_write;
        logic [7:0] fr[$];
        bit to; int end_c; int e0;
        acc_q.delete(); tx_q.delete(); exp_q.delete(); e0 = err_cnt;
        fr = {SYNC_BYTE, CMD_WRITE, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        exp_q.push_back(ACK_BYTE);
        send_frame(fr);
        wait_resp(1, to, end_c);
        n_checks++; if (to) begin n_fail++; $display("FAIL write_timeout: response not complete within %0d cycles", LIMIT); end
        n_checks++;
        if (acc_q.size() != 1) begin n_fail++; $display("FAIL write_count: got %0d accesses required 1", acc_q.size()); end
        else begin
            acc_t a = acc_q.pop_front();
            n_checks++;
            if ({a.we, a.addr, a.wdata} !== {1'b1, 13'h010, 32'hDEADBEEF}) begin
                n_fail++; $display("FAIL write_access: got we=%b addr=%h data=%h required we=1 addr=010 data=deadbeef", a.we, a.addr, a.wdata);
            end
        end
        n_checks++;
        if (tx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL write_resp_len: got %0d bytes required %0d", tx_q.size(), exp_q.size()); end
        else begin
            int first = tx_q[0].cyc;
            while (exp_q.size() > 0) begin
                txb_t b = tx_q.pop_front(); logic [7:0] e = exp_q.pop_front();
                n_checks++;
                if ({b.data, b.stop} !== {e, 1'b1}) begin n_fail++; $display("FAIL write_resp: got %h stop=%b required %h stop=1", b.data, b.stop, e); end
            end
            n_checks++;
            if (end_c - first != int'(10*CPB)) begin n_fail++; $display("FAIL write_resp_time: got %0d cycles required %0d", end_c - first, 10*CPB); end
        end
        n_checks++;
        if (err_cnt != e0) begin n_fail++; $display("FAIL write_err: got %0d err pulses required 0", err_cnt - e0); end
    endtask

    task automatic test_read;
        logic [7:0] fr[$];
        bit to; int end_c;
        acc_q.delete(); tx_q.delete(); exp_q.delete();
        fr = {SYNC_BYTE, CMD_READ, 8'h00, 8'h10};
        exp_q = {ACK_BYTE, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(fr);
        wait_resp(5, to, end_c);
        n_checks++; if (to) begin n_fail++; $display("FAIL read_timeout: response not complete within %0d cycles", LIMIT); end
        n_checks++;
        if (acc_q.size() != 1) begin n_fail++; $display("FAIL read_count: got %0d accesses required 1", acc_q.size()); end
        else begin
            acc_t a = acc_q.pop_front();
            n_checks++;
            if ({a.we, a.addr} !== {1'b0, 13'h010}) begin n_fail++; $display("FAIL read_access: got we=%b addr=%h required we=0 addr=010", a.we, a.addr); end
        end
        n_checks++;
        if (tx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL read_resp_len: got %0d bytes required %0d", tx_q.size(), exp_q.size()); end
        else begin
            int first = tx_q[0].cyc;
            int idx = 0;
            while (exp_q.size() > 0) begin
                txb_t b = tx_q.pop_front(); logic [7:0] e = exp_q.pop_front();
                n_checks++;
                if ({b.data, b.stop} !== {e, 1'b1}) begin n_fail++; $display("FAIL read_resp_%0d: got %h stop=%b required %h stop=1", idx, b.data, b.stop, e); end
                idx++;
            end
            // Five bytes back-to-back, idle the cycle after the last stop bit.
            n_checks++;
            if (end_c - first != int'(50*CPB)) begin n_fail++; $display("FAIL read_resp_time: got %0d cycles required %0d", end_c - first, 50*CPB); end
        end
    endtask

    task automatic test_core_reset;
        logic [7:0] fr[$];
        logic [7:0] cmds[2];
        logic       lvl[2];
        bit to; int end_c; int e0;
        cmds = '{CMD_RST_SET, CMD_RST_CLR};
        lvl  = '{1'b1, 1'b0};
        tx_q.delete(); exp_q.delete(); e0 = err_cnt;
        send_byte(8'h33, 1'b1);
        n_checks++;
        if (busy !== 1'b0 || err_cnt != e0 || tx_q.size() != 0) begin
            n_fail++; $display("FAIL idle_junk: got busy=%b err=%0d tx=%0d required busy=0 err=0 tx=0", busy, err_cnt - e0, tx_q.size());
        end
        for (int c = 0; c < 2; c++) begin
            acc_q.delete(); tx_q.delete(); exp_q.delete();
            fr = {SYNC_BYTE, cmds[c], 8'h00, 8'h00};
            exp_q.push_back(ACK_BYTE);
            send_frame(fr);
            wait_resp(1, to, end_c);
            n_checks++;
            if (to || core_reset !== lvl[c]) begin n_fail++; $display("FAIL core_reset_%0d: got %b timeout=%b required %b", c, core_reset, to, lvl[c]); end
            n_checks++;
            if (acc_q.size() != 0) begin n_fail++; $display("FAIL core_reset_access_%0d: got %0d accesses required 0", c, acc_q.size()); end
            n_checks++;
            if (tx_q.size() != 1) begin n_fail++; $display("FAIL core_reset_resp_len_%0d: got %0d bytes required 1", c, tx_q.size()); end
            else begin
                txb_t b = tx_q.pop_front(); logic [7:0] e = exp_q.pop_front();
                n_checks++;
                if (b.data !== e) begin n_fail++; $display("FAIL core_reset_resp_%0d: got %h required %h", c, b.data, e); end
            end
        end
    endtask

    task automatic test_addr_err;
        logic [7:0] fr[$];
        bit to; int end_c; int e0;
        acc_q.delete(); tx_q.delete(); exp_q.delete(); e0 = err_cnt;
        fr = {SYNC_BYTE, CMD_WRITE, 8'h20, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        exp_q.push_back(NAK_BYTE);
        send_frame(fr);
        wait_resp(1, to, end_c);
        n_checks++;
        if (to || acc_q.size() != 0) begin n_fail++; $display("FAIL addr_err_access: got %0d accesses timeout=%b required 0", acc_q.size(), to); end
        n_checks++;
        if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL addr_err_pulse: got %0d err pulses required 1", err_cnt - e0); end
        n_checks++;
        if (tx_q.size() != 1) begin n_fail++; $display("FAIL addr_err_resp_len: got %0d bytes required 1", tx_q.size()); end
        else begin
            txb_t b = tx_q.pop_front(); logic [7:0] e = exp_q.pop_front();
            n_checks++;
            if (b.data !== e) begin n_fail++; $display("FAIL addr_err_resp: got %h required %h", b.data, e); end
        end
    endtask

    task automatic test_ferr_timeout;
        logic [7:0] fr[$];
        bit to; int end_c; int e0;
        acc_q.delete(); tx_q.delete(); exp_q.delete(); e0 = err_cnt;
        fr = {SYNC_BYTE, CMD_WRITE};
        send_frame(fr);
        send_byte(8'h00, 1'b0);
        n_checks++;
        if (err_cnt - e0 != 1 || busy !== 1'b1) begin n_fail++; $display("FAIL ferr_pulse: got err=%0d busy=%b required err=1 busy=1", err_cnt - e0, busy); end
        repeat (TMO + 100) @(negedge clk);
        n_checks++;
        if (err_cnt - e0 != 2 || busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got err=%0d busy=%b required err=2 busy=0", err_cnt - e0, busy); end
        n_checks++;
        if (tx_q.size() != 0 || acc_q.size() != 0) begin n_fail++; $display("FAIL timeout_silent: got tx=%0d acc=%0d required 0 0", tx_q.size(), acc_q.size()); end
        fr = {SYNC_BYTE, CMD_WRITE, 8'h00, 8'h20, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        exp_q.push_back(ACK_BYTE);
        send_frame(fr);
        wait_resp(1, to, end_c);
        n_checks++;
        if (to || acc_q.size() != 1) begin n_fail++; $display("FAIL after_timeout_count: got %0d accesses timeout=%b required 1", acc_q.size(), to); end
        else begin
            acc_t a = acc_q.pop_front();
            n_checks++;
            if ({a.we, a.addr, a.wdata} !== {1'b1, 13'h020, 32'hCAFEBABE}) begin
                n_fail++; $display("FAIL after_timeout_access: got we=%b addr=%h data=%h required we=1 addr=020 data=cafebabe", a.we, a.addr, a.wdata);
            end
        end
        n_checks++;
        if (tx_q.size() != 1 || tx_q[0].data !== exp_q[0]) begin n_fail++; $display("FAIL after_timeout_resp: got %0d bytes required one byte %h", tx_q.size(), exp_q[0]); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] fr[$];
        bit to; int end_c;
        acc_q.delete(); tx_q.delete(); exp_q.delete();
        fr = {SYNC_BYTE, CMD_WRITE, 8'h00, 8'h30, 8'h11, 8'h22};
        send_frame(fr);
        rxd = 1'b0;
        repeat (3*CPB) @(negedge clk);
        resetb = 1'b0;
        #1;
        check_reset_values("midreset");
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        resetb = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (acc_q.size() != 0) begin n_fail++; $display("FAIL midreset_access: got %0d accesses required 0", acc_q.size()); end
        fr = {SYNC_BYTE, CMD_WRITE, 8'h00, 8'h31, 8'h01, 8'h02, 8'h03, 8'h04};
        exp_q.push_back(ACK_BYTE);
        send_frame(fr);
        wait_resp(1, to, end_c);
        n_checks++;
        if (to || acc_q.size() != 1) begin n_fail++; $display("FAIL post_reset_count: got %0d accesses timeout=%b required 1", acc_q.size(), to); end
        else begin
            acc_t a = acc_q.pop_front();
            n_checks++;
            if ({a.we, a.addr, a.wdata} !== {1'b1, 13'h031, 32'h01020304}) begin
                n_fail++; $display("FAIL post_reset_access: got we=%b addr=%h data=%h required we=1 addr=031 data=01020304", a.we, a.addr, a.wdata);
            end
        end
        n_checks++;
        if (tx_q.size() != 1 || tx_q[0].data !== exp_q[0]) begin n_fail++; $display("FAIL post_reset_resp: got %0d bytes required one byte %h", tx_q.size(), exp_q[0]); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_core_reset();
        test_addr_err();
        test_ferr_timeout();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
